// File: rtl/sram_arbiter.sv
// sram_arbiter: sequences the single external SRAM port between the screen
// fetch (video), the CPU and a DMA engine. One access at a time: a fixed
// ACC_CYCLES strobe window, then a one-cycle bus turnaround after writes.
// Priority is video > CPU > DMA; a starvation counter lifts DMA above CPU.
module sram_arbiter #(
   parameter int unsigned AW           = 19,
   parameter int unsigned ACC_CYCLES   = 3,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic          clk28,
   input  logic          rst_n,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_addr,
   output logic          vid_ack,
   output logic [7:0]    vid_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic          cpu_ack,
   output logic [7:0]    cpu_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [7:0]    dma_wdata,
   output logic          dma_ack,
   output logic [7:0]    dma_rdata,
   output logic [AW-1:0] sram_a,
   output logic [7:0]    sram_dout,
   output logic          sram_doe,
   input  logic [7:0]    sram_din,
   output logic          n_vrd,
   output logic          n_vwr,
   output logic [1:0]    owner
);

   localparam int unsigned CW = (ACC_CYCLES > 2) ? $clog2(ACC_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(ACC_CYCLES - 1);
   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_TURN} state_t;
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_VID = 2'd1,
                             OWN_CPU = 2'd2, OWN_DMA = 2'd3} owner_t;

   state_t          r_state, w_next;
   owner_t          r_owner, w_sel;
   logic [CW-1:0]   r_cnt;
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [7:0]      r_wdata;
   logic [7:0]      r_starve;
   logic            r_vid_ack, r_cpu_ack, r_dma_ack;
   logic [7:0]      r_vid_rdata, r_cpu_rdata, r_dma_rdata;
   logic            w_grant;
   logic            w_last;

   // Pick the winner among current requests (only acted on while IDLE)
   always_comb begin
      w_sel = OWN_NONE;
      if (vid_req)
         w_sel = OWN_VID;
      else if (dma_req && (r_starve == STARVE_MAX))
         w_sel = OWN_DMA;
      else if (cpu_req)
         w_sel = OWN_CPU;
      else if (dma_req)
         w_sel = OWN_DMA;
   end

   assign w_grant = (r_state == S_IDLE) && (w_sel != OWN_NONE);
   assign w_last  = (r_state == S_ACCESS) && (r_cnt == LAST_CNT);

   // State register
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic: reads return straight to IDLE, writes pass through TURN
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_grant) w_next = S_ACCESS;
         S_ACCESS: if (w_last)  w_next = r_we ? S_TURN : S_IDLE;
         S_TURN:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Latch the winner's request at grant, count the strobe window, capture
   // read data and raise the single-cycle ack at the end of the window
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= OWN_NONE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_vid_ack   <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_dma_ack   <= 1'b0;
         r_vid_rdata <= '0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_vid_ack <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_dma_ack <= 1'b0;
         if (w_grant) begin
            r_owner <= w_sel;
            r_cnt   <= '0;
            case (w_sel)
               OWN_VID: begin
                  r_addr  <= vid_addr;
                  r_we    <= 1'b0;
                  r_wdata <= '0;
               end
               OWN_CPU: begin
                  r_addr  <= cpu_addr;
                  r_we    <= cpu_we;
                  r_wdata <= cpu_wdata;
               end
               default: begin
                  r_addr  <= dma_addr;
                  r_we    <= dma_we;
                  r_wdata <= dma_wdata;
               end
            endcase
         end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               case (r_owner)
                  OWN_VID: begin
                     r_vid_ack   <= 1'b1;
                     r_vid_rdata <= sram_din;
                  end
                  OWN_CPU: begin
                     r_cpu_ack <= 1'b1;
                     if (!r_we) r_cpu_rdata <= sram_din;
                  end
                  OWN_DMA: begin
                     r_dma_ack <= 1'b1;
                     if (!r_we) r_dma_rdata <= sram_din;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Starvation counter: counts video/CPU grants made while DMA is waiting
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n)
         r_starve <= '0;
      else if (!dma_req)
         r_starve <= '0;
      else if (w_grant && (w_sel == OWN_DMA))
         r_starve <= '0;
      else if (w_grant && (r_starve != STARVE_MAX))
         r_starve <= r_starve + 8'd1;
   end

   // Output decode: strobes and drive enable follow the registered state, so
   // an asynchronous reset releases the bus immediately
   always_comb begin
      n_vrd    = !((r_state == S_ACCESS) && !r_we);
      n_vwr    = !((r_state == S_ACCESS) && r_we && (r_cnt != '0));
      sram_doe = r_we && (r_state != S_IDLE);
      owner    = (r_state == S_IDLE) ? OWN_NONE : r_owner;
   end

   assign sram_a    = r_addr;
   assign sram_dout = r_wdata;
   assign vid_ack   = r_vid_ack;
   assign cpu_ack   = r_cpu_ack;
   assign dma_ack   = r_dma_ack;
   assign vid_rdata = r_vid_rdata;
   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus with a scoreboard. Drivers push the
// expected completion per requester; a monitor pops and compares on each ack.
module tb_sram_arbiter;

   localparam int unsigned AW = 19;

   logic          clk28 = 1'b0;
   logic          rst_n;
   logic          vid_req, cpu_req, cpu_we, dma_req, dma_we;
   logic [AW-1:0] vid_addr, cpu_addr, dma_addr;
   logic [7:0]    cpu_wdata, dma_wdata;
   logic          vid_ack, cpu_ack, dma_ack;
   logic [7:0]    vid_rdata, cpu_rdata, dma_rdata;
   logic [AW-1:0] sram_a;
   logic [7:0]    sram_dout, sram_din;
   logic          sram_doe, n_vrd, n_vwr;
   logic [1:0]    owner;

   always #5 clk28 = ~clk28;

   sram_arbiter #(.AW(AW), .ACC_CYCLES(3), .STARVE_LIMIT(8)) dut (
      .clk28(clk28), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .sram_a(sram_a), .sram_dout(sram_dout), .sram_doe(sram_doe), .sram_din(sram_din),
      .n_vrd(n_vrd), .n_vwr(n_vwr), .owner(owner)
   );

   // SRAM model, indexed by the low 12 address bits
   logic [7:0] mem [0:4095];
   always_comb sram_din = mem[sram_a[11:0]];
   always @(negedge clk28) if (!n_vwr && sram_doe) mem[sram_a[11:0]] = sram_dout;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } exp_t;

   exp_t q_vid[$], q_cpu[$], q_dma[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   gseq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic mon(input int src, input logic [7:0] rdata);
      exp_t  e;
      int    sz;
      string nm;
      case (src)
         1: begin sz = q_vid.size(); nm = "vid"; end
         2: begin sz = q_cpu.size(); nm = "cpu"; end
         default: begin sz = q_dma.size(); nm = "dma"; end
      endcase
      if (sz == 0) begin
         n_checks++;
         $display("FAIL %s_ack: got unexpected ack expected none", nm);
         return;
      end
      case (src)
         1: e = q_vid.pop_front();
         2: e = q_cpu.pop_front();
         default: e = q_dma.pop_front();
      endcase
      if (e.we) chk({nm, "_wr_mem"}, {24'd0, mem[e.addr[11:0]]}, {24'd0, e.data});
      else      chk({nm, "_rdata"}, {24'd0, rdata}, {24'd0, e.data});
   endtask

   // Monitor: every ack consumes exactly one expected completion
   always @(negedge clk28) begin
      if (rst_n === 1'b1) begin
         if (vid_ack) mon(1, vid_rdata);
         if (cpu_ack) mon(2, cpu_rdata);
         if (dma_ack) mon(3, dma_rdata);
      end
   end

   // Issue one access, hold req until its ack, then release
   task automatic access(input int src, input logic we, input logic [AW-1:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd);
      exp_t e;
      logic got;
      e = '{we, addr, (we ? wdata : exp_rd)};
      got = 1'b0;
      case (src)
         1: begin q_vid.push_back(e); vid_addr = addr; vid_req = 1'b1; end
         2: begin q_cpu.push_back(e); cpu_addr = addr; cpu_we = we; cpu_wdata = wdata; cpu_req = 1'b1; end
         default: begin q_dma.push_back(e); dma_addr = addr; dma_we = we; dma_wdata = wdata; dma_req = 1'b1; end
      endcase
      for (int i = 0; i < 100; i++) begin
         @(negedge clk28);
         if ((src == 1 && vid_ack) || (src == 2 && cpu_ack) || (src == 3 && dma_ack)) begin
            got = 1'b1;
            break;
         end
      end
      case (src)
         1: vid_req = 1'b0;
         2: cpu_req = 1'b0;
         default: dma_req = 1'b0;
      endcase
      if (!got) begin
         n_checks++;
         $display("FAIL ack_timeout src%0d: got no ack expected ack", src);
      end
   endtask

   // Record the owner of each new grant (owner rising from 0)
   task automatic record(input int cycles);
      logic [1:0] prev;
      prev = 2'd0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk28);
         if (owner != 2'd0 && prev == 2'd0) gseq.push_back(int'(owner));
         prev = owner;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cpu_acks;
      int nack;
      logic [1:0] prev;
      for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
      mem[12'h345] = 8'hA5; mem[12'h200] = 8'hC2; mem[12'h300] = 8'hD3;
      mem[12'h400] = 8'hB4; mem[12'h500] = 8'hC5; mem[12'h700] = 8'h11;
      mem[12'h800] = 8'h5A;
      rst_n = 1'b0;
      vid_req = 0; cpu_req = 0; dma_req = 0; cpu_we = 0; dma_we = 0;
      vid_addr = '0; cpu_addr = '0; dma_addr = '0; cpu_wdata = '0; dma_wdata = '0;

      // Reset state
      @(negedge clk28); @(negedge clk28);
      chk("rst_strobes", {n_vrd, n_vwr, sram_doe}, 3'b110);
      chk("rst_sram_a", sram_a, 0);
      chk("rst_dout", sram_dout, 0);
      chk("rst_acks", {vid_ack, cpu_ack, dma_ack}, 0);
      chk("rst_rdata", {vid_rdata, cpu_rdata, dma_rdata}, 0);
      chk("rst_owner", owner, 0);
      rst_n = 1'b1;
      @(negedge clk28);

      // CPU read: 3 strobe cycles, ack in cycle 4
      q_cpu.push_back('{1'b0, 19'h12345, 8'hA5});
      cpu_addr = 19'h12345; cpu_we = 1'b0; cpu_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk28);
         if (c < 4) begin
            chk("rd_nvrd", n_vrd, 0);
            chk("rd_addr", sram_a, 19'h12345);
            chk("rd_owner", owner, 2);
            chk("rd_nack", cpu_ack, 0);
         end else begin
            chk("rd_ack", cpu_ack, 1);
            chk("rd_nvrd_end", n_vrd, 1);
            chk("rd_owner_end", owner, 0);
            cpu_req = 1'b0;
         end
      end

      // CPU write: doe for 4 cycles, n_vwr low in cycles 2-3, ack in TURN
      q_cpu.push_back('{1'b1, 19'h00100, 8'h3C});
      cpu_addr = 19'h00100; cpu_we = 1'b1; cpu_wdata = 8'h3C; cpu_req = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk28);
         case (c)
            1: begin
               chk("wr_c1", {sram_doe, n_vwr, n_vrd}, 3'b111);
               chk("wr_addr", sram_a, 19'h00100);
               chk("wr_dout", sram_dout, 8'h3C);
            end
            2, 3: chk("wr_strobe", {sram_doe, n_vwr, n_vrd}, 3'b101);
            4: begin
               chk("wr_turn", {sram_doe, n_vwr, cpu_ack}, 3'b111);
               chk("wr_turn_owner", owner, 2);
               cpu_req = 1'b0;
            end
            default: chk("wr_idle", {sram_doe, cpu_ack, owner}, 4'b0000);
         endcase
      end

      // Simultaneous requests: video, then CPU, then DMA
      gseq.delete();
      fork
         access(1, 1'b0, 19'h00400, 8'h00, 8'hB4);
         access(2, 1'b0, 19'h00500, 8'h00, 8'hC5);
         access(3, 1'b1, 19'h00600, 8'h77, 8'h00);
         record(20);
      join
      chk("sim_ngrants", gseq.size(), 3);
      if (gseq.size() == 3) begin
         chk("sim_g0", gseq[0], 1);
         chk("sim_g1", gseq[1], 2);
         chk("sim_g2", gseq[2], 3);
      end

      // Starvation: CPU held continuously with DMA waiting
      gseq.delete();
      for (int i = 0; i < 9; i++) q_cpu.push_back('{1'b0, 19'h00200, 8'hC2});
      q_dma.push_back('{1'b0, 19'h00300, 8'hD3});
      cpu_addr = 19'h00200; cpu_we = 1'b0; cpu_req = 1'b1;
      dma_addr = 19'h00300; dma_we = 1'b0; dma_req = 1'b1;
      cpu_acks = 0; prev = 2'd0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk28);
         if (owner != 2'd0 && prev == 2'd0) gseq.push_back(int'(owner));
         prev = owner;
         if (cpu_ack) begin
            cpu_acks++;
            if (cpu_acks == 9) cpu_req = 1'b0;
         end
         if (dma_ack) dma_req = 1'b0;
         if (cpu_acks == 9 && !dma_req) break;
      end
      cpu_req = 1'b0; dma_req = 1'b0;
      chk("stv_ngrants", gseq.size(), 10);
      if (gseq.size() == 10) begin
         for (int i = 0; i < 10; i++)
            chk($sformatf("stv_g%0d", i), gseq[i], (i == 8) ? 3 : 2);
      end
      @(negedge clk28);

      // Reset during the second ACCESS cycle of a write
      cpu_addr = 19'h00700; cpu_we = 1'b1; cpu_wdata = 8'h55; cpu_req = 1'b1;
      @(negedge clk28);
      chk("rw_c1_doe", sram_doe, 1);
      @(negedge clk28);
      chk("rw_c2_nvwr", n_vwr, 0);
      rst_n = 1'b0; cpu_req = 1'b0;
      #1;
      chk("rw_rst_bus", {n_vwr, sram_doe, n_vrd}, 3'b101);
      chk("rw_rst_owner", owner, 0);
      chk("rw_rst_rdata", cpu_rdata, 0);
      @(negedge clk28);
      chk("rw_rst_noack", cpu_ack, 0);
      rst_n = 1'b1;
      @(negedge clk28);
      chk("rw_post_noack", cpu_ack, 0);
      access(2, 1'b0, 19'h12345, 8'h00, 8'hA5);

      // CPU req dropped right after grant: access still completes once
      q_cpu.push_back('{1'b0, 19'h00800, 8'h5A});
      cpu_addr = 19'h00800; cpu_we = 1'b0; cpu_req = 1'b1;
      @(negedge clk28);
      chk("drop_owner", owner, 2);
      cpu_req = 1'b0;
      nack = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk28);
         if (cpu_ack) nack++;
      end
      chk("drop_nacks", nack, 1);

      repeat (3) @(negedge clk28);
      chk("sb_empty", q_vid.size() + q_cpu.size() + q_dma.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
